// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request/response and RAM-port bundle for the byte-serial memory controller
//
// Ports grouped here:
//   memctl_op/len/addr/data -> controller    MEM-stage request
//   memctl_fin/out          <- controller    MEM-stage completion pulse and load data
//   if_req/if_addr          -> controller    IF-stage word fetch request
//   if_fin/if_data          <- controller    fetch completion pulse and word
//   mem_din                 -> controller    RAM read data (one cycle after mem_a)
//   mem_dout/mem_a/mem_wr   <- controller    RAM write data, byte address, write strobe
// Modports: slave = controller side, master = requesters plus RAM.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        memctl_op;
    logic [1:0]        memctl_len;
    logic [31:0]       memctl_addr;
    logic [31:0]       memctl_data;
    logic              memctl_fin;
    logic [31:0]       memctl_out;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_fin;
    logic [31:0]       if_data;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  memctl_op, memctl_len, memctl_addr, memctl_data, if_req, if_addr, mem_din,
        output memctl_fin, memctl_out, if_fin, if_data, mem_dout, mem_a, mem_wr
    );

    modport master (
        output memctl_op, memctl_len, memctl_addr, memctl_data, if_req, if_addr, mem_din,
        input  memctl_fin, memctl_out, if_fin, if_data, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller arbitrating MEM loads/stores and IF fetches
//
// Ports:
//   clk_in   clock, all state on the rising edge
//   rst_in   asynchronous reset, active-low
//   rdy_in   0 freezes FSM and output registers; mem_wr forced 0
//   bus      mem_ctrl_if.slave: MEM request/response, IF fetch, 8-bit RAM port
// Parameters:
//   ADDR_W        RAM address width; upper request-address bits are dropped
//   MEM_PRIORITY  1: MEM port wins simultaneous requests, 0: IF port wins
module mem_ctrl #(
    parameter int ADDR_W       = 32,
    parameter bit MEM_PRIORITY = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    mem_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t            state;
    logic              own_if;      // 1: current transaction belongs to the IF port
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [2:0]        n_q;         // bytes in this transaction: 1, 2 or 4
    logic [2:0]        idx_q;       // next byte index to put on mem_a / mem_dout
    logic [2:0]        cap_q;       // bytes of read data captured so far
    logic              live_q;      // mem_a currently carries a read byte
    logic              pend_q;      // a read was issued last rdy cycle; mem_din holds it now
    logic [31:0]       buf_q;
    logic              wr_q;
    logic [ADDR_W-1:0] a_q;
    logic [7:0]        dout_q;
    logic              mfin_q;
    logic              ifin_q;
    logic [31:0]       mout_q;
    logic [31:0]       ifdata_q;

    logic              mem_req;
    logic              grant_mem;
    logic              grant_if;
    logic [2:0]        req_n;
    logic [2:0]        cap_next;
    logic [31:0]       addr_i;
    logic [31:0]       rd_next;

    assign mem_req   = (bus.memctl_op == 2'b01) || (bus.memctl_op == 2'b10);
    assign grant_mem = mem_req && (MEM_PRIORITY || !bus.if_req);
    assign grant_if  = bus.if_req && !grant_mem;
    assign req_n     = (bus.memctl_len == 2'b00) ? 3'd1 :
                       (bus.memctl_len == 2'b01) ? 3'd2 : 3'd4;
    assign cap_next  = cap_q + {2'b00, pend_q};
    // 32-bit sum so addresses wrap past 0xFFFFFFFF before truncation to ADDR_W
    assign addr_i    = addr_q + {29'd0, idx_q};

    // Read buffer with the in-flight byte merged in, so the completing edge can
    // publish the full word without an extra cycle.
    always_comb begin
        rd_next = buf_q;
        if (pend_q) begin
            rd_next[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= S_IDLE;
            own_if   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            cap_q    <= '0;
            live_q   <= 1'b0;
            pend_q   <= 1'b0;
            buf_q    <= '0;
            wr_q     <= 1'b0;
            a_q      <= '0;
            dout_q   <= '0;
            mfin_q   <= 1'b0;
            ifin_q   <= 1'b0;
            mout_q   <= '0;
            ifdata_q <= '0;
        end else begin
            // The RAM returns data for last cycle's address even during a stall,
            // so capture is not gated by rdy_in.
            if (state == S_RD && pend_q) begin
                buf_q  <= rd_next;
                cap_q  <= cap_next;
                pend_q <= 1'b0;
            end

            if (rdy_in) begin
                case (state)
                    S_IDLE: begin
                        if (grant_mem || grant_if) begin
                            own_if <= grant_if;
                            addr_q <= grant_if ? bus.if_addr : bus.memctl_addr;
                            data_q <= bus.memctl_data;
                            n_q    <= grant_if ? 3'd4 : req_n;
                            a_q    <= ADDR_W'(grant_if ? bus.if_addr : bus.memctl_addr);
                            idx_q  <= 3'd1;
                            cap_q  <= '0;
                            pend_q <= 1'b0;
                            buf_q  <= '0;
                            if (grant_mem && bus.memctl_op == 2'b10) begin
                                wr_q   <= 1'b1;
                                dout_q <= bus.memctl_data[7:0];
                                state  <= S_WR;
                            end else begin
                                live_q <= 1'b1;
                                state  <= S_RD;
                            end
                        end
                    end
                    S_RD: begin
                        pend_q <= live_q;
                        if (cap_next == n_q) begin
                            live_q <= 1'b0;
                            a_q    <= '0;
                            state  <= S_DONE;
                            if (own_if) begin
                                ifin_q   <= 1'b1;
                                ifdata_q <= rd_next;
                            end else begin
                                mfin_q <= 1'b1;
                                mout_q <= rd_next;
                            end
                        end else if (idx_q < n_q) begin
                            a_q    <= ADDR_W'(addr_i);
                            idx_q  <= idx_q + 3'd1;
                            live_q <= 1'b1;
                        end else begin
                            // last byte issued; wait for its data to come back
                            live_q <= 1'b0;
                            a_q    <= '0;
                        end
                    end
                    S_WR: begin
                        if (idx_q < n_q) begin
                            a_q    <= ADDR_W'(addr_i);
                            dout_q <= data_q[{idx_q[1:0], 3'b000} +: 8];
                            idx_q  <= idx_q + 3'd1;
                        end else begin
                            wr_q   <= 1'b0;
                            a_q    <= '0;
                            dout_q <= '0;
                            mfin_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // requests seen here are deliberately ignored
                        mfin_q <= 1'b0;
                        ifin_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.memctl_fin = mfin_q;
    assign bus.memctl_out = mout_q;
    assign bus.if_fin     = ifin_q;
    assign bus.if_data    = ifdata_q;
    assign bus.mem_a      = a_q;
    assign bus.mem_dout   = dout_q;
    assign bus.mem_wr     = wr_q & rdy_in;
endmodule
